// File: rtl/ftdi_tx_scheduler.sv
// ftdi_tx_scheduler
// Round-robin arbiter between two packet sources (bulk data, status/ack) that
// streams one packet at a time into the FTDI 1 KiB packet queue, fires the
// frame-padding strobe, then holds off the next grant until the frame drains.
// The byte path (ready / wrreq / data_wr) is a zero-latency passthrough;
// all control strobes except overrun come straight from flops.
module ftdi_tx_scheduler #(
    parameter int FRAME_BYTES  = 1024,
    parameter int DRAIN_CYCLES = 1100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       abort,
    input  logic       src0_req,
    input  logic       src1_req,
    input  logic       src0_valid,
    input  logic       src1_valid,
    input  logic [7:0] src0_data,
    input  logic [7:0] src1_data,
    input  logic       src0_last,
    input  logic       src1_last,
    output logic       src0_ready,
    output logic       src1_ready,
    output logic [1:0] grant,
    output logic [1:0] pkt_done,
    output logic       overrun,
    input  logic       wrq_full,
    input  logic       wrq_empty,
    output logic       wrreq,
    output logic [7:0] data_wr,
    output logic       load_1k,
    output logic       wr_clear,
    output logic       wr_en
);

    // byte_ct must be able to hold FRAME_BYTES itself, hence the extra bit.
    localparam int              BCW        = $clog2(FRAME_BYTES) + 1;
    localparam logic [BCW-1:0]  FRAME_LIM  = BCW'(FRAME_BYTES);
    localparam logic [BCW-1:0]  FRAME_LAST = BCW'(FRAME_BYTES - 1);
    localparam logic [BCW-1:0]  BYTE_ONE   = BCW'(1);
    localparam logic [15:0]     DRAIN_LOAD = 16'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        DISCARD = 3'd2,
        LOAD    = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    // Registered state
    state_t           state_r;
    logic [1:0]       grant_r;
    logic             last_grant_r;   // 1 = src1 owned the last completed frame
    logic [BCW-1:0]   byte_ct_r;
    logic [15:0]      drain_ct_r;
    logic [1:0]       pkt_done_r;
    logic             load_1k_r;
    logic             wr_en_r;
    logic             wr_clear_r;

    // Next-state / combinational signals
    state_t           state_s;
    logic [1:0]       grant_s;
    logic             last_grant_s;
    logic [BCW-1:0]   byte_ct_s;
    logic [15:0]      drain_ct_s;
    logic [1:0]       pkt_done_s;

    logic             owner_valid_s;
    logic             owner_last_s;
    logic [7:0]       owner_data_s;
    logic             path_ready_s;
    logic             accept_s;
    logic             wrreq_s;
    logic             overrun_s;

    // Owner byte-path mux and handshake: ready only for the granted source,
    // suppressed by a full queue (FILL only), a full frame, or a flush.
    always_comb begin
        owner_valid_s = 1'b0;
        owner_last_s  = 1'b0;
        owner_data_s  = 8'h00;
        path_ready_s  = 1'b0;
        if (grant_r[1]) begin
            owner_valid_s = src1_valid;
            owner_last_s  = src1_last;
            owner_data_s  = src1_data;
        end else begin
            owner_valid_s = src0_valid;
            owner_last_s  = src0_last;
            owner_data_s  = src0_data;
        end
        if (abort) begin
            path_ready_s = 1'b0;
        end else if (state_r == FILL) begin
            path_ready_s = !wrq_full && (byte_ct_r < FRAME_LIM);
        end else if (state_r == DISCARD) begin
            path_ready_s = 1'b1;
        end else begin
            path_ready_s = 1'b0;
        end
        accept_s  = path_ready_s && owner_valid_s;
        wrreq_s   = accept_s && (state_r == FILL);
        overrun_s = wrreq_s && !owner_last_s && (byte_ct_r == FRAME_LAST);
    end

    // FSM next-state: arbitration, byte counting, drain timing and flush.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        byte_ct_s    = byte_ct_r;
        drain_ct_s   = drain_ct_r;
        pkt_done_s   = 2'b00;
        if (abort) begin
            state_s = IDLE;
            grant_s = 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (src0_req || src1_req) begin
                        if (src0_req && src1_req) begin
                            grant_s = last_grant_r ? 2'b01 : 2'b10;
                        end else if (src0_req) begin
                            grant_s = 2'b01;
                        end else begin
                            grant_s = 2'b10;
                        end
                        byte_ct_s = {BCW{1'b0}};
                        state_s   = FILL;
                    end else begin
                        state_s = IDLE;
                    end
                end
                FILL: begin
                    if (accept_s) begin
                        byte_ct_s = byte_ct_r + BYTE_ONE;
                        if (owner_last_s) begin
                            state_s = LOAD;
                        end else if (byte_ct_r == FRAME_LAST) begin
                            state_s = DISCARD;
                        end else begin
                            state_s = FILL;
                        end
                    end else begin
                        state_s = FILL;
                    end
                end
                DISCARD: begin
                    if (accept_s && owner_last_s) begin
                        state_s = LOAD;
                    end else begin
                        state_s = DISCARD;
                    end
                end
                LOAD: begin
                    drain_ct_s = DRAIN_LOAD;
                    state_s    = DRAIN;
                end
                DRAIN: begin
                    if (drain_ct_r == 16'd0) begin
                        if (wrq_empty) begin
                            pkt_done_s   = grant_r;
                            last_grant_s = grant_r[1];
                            grant_s      = 2'b00;
                            state_s      = IDLE;
                        end else begin
                            state_s = DRAIN;
                        end
                    end else begin
                        drain_ct_s = drain_ct_r - 16'd1;
                        state_s    = DRAIN;
                    end
                end
                default: begin
                    state_s = IDLE;
                    grant_s = 2'b00;
                end
            endcase
        end
    end

    // State, counters and registered control strobes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            grant_r      <= 2'b00;
            last_grant_r <= 1'b1;
            byte_ct_r    <= {BCW{1'b0}};
            drain_ct_r   <= 16'd0;
            pkt_done_r   <= 2'b00;
            load_1k_r    <= 1'b0;
            wr_en_r      <= 1'b0;
            wr_clear_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            byte_ct_r    <= byte_ct_s;
            drain_ct_r   <= drain_ct_s;
            pkt_done_r   <= pkt_done_s;
            load_1k_r    <= (state_s == LOAD);
            wr_en_r      <= (state_s == LOAD) || (state_s == DRAIN);
            wr_clear_r   <= abort;
        end
    end

    assign grant      = grant_r;
    assign pkt_done   = pkt_done_r;
    assign load_1k    = load_1k_r;
    assign wr_en      = wr_en_r;
    assign wr_clear   = wr_clear_r;
    assign src0_ready = path_ready_s && grant_r[0];
    assign src1_ready = path_ready_s && grant_r[1];
    assign wrreq      = wrreq_s;
    assign data_wr    = owner_data_s;
    assign overrun    = overrun_s;

endmodule

// File: tb/tb_ftdi_tx_scheduler.sv
// tb_ftdi_tx_scheduler
// Scoreboarded bench: expected bytes are queued per source as they are driven
// and popped when the scheduler pushes them into the packet queue.
module tb_ftdi_tx_scheduler;

    localparam int FRAME = 1024;
    localparam int DRAIN = 1100;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       abort = 1'b0;
    logic       src0_req = 1'b0, src1_req = 1'b0;
    logic       src0_valid = 1'b0, src1_valid = 1'b0;
    logic [7:0] src0_data = 8'h00, src1_data = 8'h00;
    logic       src0_last = 1'b0, src1_last = 1'b0;
    logic       src0_ready, src1_ready;
    logic [1:0] grant, pkt_done;
    logic       overrun;
    logic       wrq_full = 1'b0;
    logic       wrq_empty = 1'b1;
    logic       wrreq;
    logic [7:0] data_wr;
    logic       load_1k, wr_clear, wr_en;

    ftdi_tx_scheduler #(.FRAME_BYTES(FRAME), .DRAIN_CYCLES(DRAIN)) dut (
        .clock(clock), .reset(reset), .abort(abort),
        .src0_req(src0_req), .src1_req(src1_req),
        .src0_valid(src0_valid), .src1_valid(src1_valid),
        .src0_data(src0_data), .src1_data(src1_data),
        .src0_last(src0_last), .src1_last(src1_last),
        .src0_ready(src0_ready), .src1_ready(src1_ready),
        .grant(grant), .pkt_done(pkt_done), .overrun(overrun),
        .wrq_full(wrq_full), .wrq_empty(wrq_empty),
        .wrreq(wrreq), .data_wr(data_wr), .load_1k(load_1k),
        .wr_clear(wr_clear), .wr_en(wr_en)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard and event log
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [1:0] grant_log[$];
    int cyc = 0;
    int wrreq_n = 0, load_n = 0, done_n = 0, overrun_n = 0, clear_n = 0;
    int overrun_at = 0, last_acc_cyc = -10, load_cyc = 0, done_cyc = 0;
    logic [1:0] load_owner = 2'b00, last_done = 2'b00, prev_grant = 2'b00;
    logic prev_load = 1'b0;

    // Cycle counter
    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor: scoreboard pop, strobe timing and grant sequence.
    always @(negedge clock) begin
        if (!reset) begin
            if (wrreq) begin
                wrreq_n++;
                if (grant == 2'b10) begin
                    if (exp_q1.size() == 0) check_eq("wrreq_unexpected_src1", 1, 0);
                    else check_eq("data_wr_src1", data_wr, exp_q1.pop_front());
                end else begin
                    if (exp_q0.size() == 0) check_eq("wrreq_unexpected_src0", 1, 0);
                    else check_eq("data_wr_src0", data_wr, exp_q0.pop_front());
                end
            end
            if (overrun) begin
                overrun_n++;
                overrun_at = wrreq_n;
            end
            if (load_1k) begin
                check_eq("load_1k_double", prev_load, 0);
                check_eq("load_after_last", cyc, last_acc_cyc + 1);
                load_n++;
                load_cyc   = cyc;
                load_owner = grant;
            end
            if (pkt_done != 2'b00) begin
                check_eq("pkt_done_owner", pkt_done, load_owner);
                check_eq("pkt_done_min_spacing", (cyc - load_cyc) >= DRAIN, 1);
                check_eq("grant_idle_at_done", grant, 0);
                done_n++;
                done_cyc  = cyc;
                last_done = pkt_done;
            end
            if (wr_clear) clear_n++;
            if ((src0_ready && src0_valid && src0_last) || (src1_ready && src1_valid && src1_last))
                last_acc_cyc = cyc;
            if (grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(grant);
            prev_load  = load_1k;
            prev_grant = grant;
        end
    end

    // Drive one packet from a source; expected bytes are queued as driven.
    task automatic send_pkt(input int src, input int n, input int base, input bit with_last);
        logic [7:0] d;
        bit lst, got;
        int w;
        for (int k = 0; k < n; k++) begin
            d   = 8'(base + k);
            lst = with_last && (k == n - 1);
            if (k < FRAME) begin
                if (src == 0) exp_q0.push_back(d);
                else exp_q1.push_back(d);
            end
            if (src == 0) begin src0_valid = 1'b1; src0_data = d; src0_last = lst; end
            else begin src1_valid = 1'b1; src1_data = d; src1_last = lst; end
            got = 1'b0;
            w   = 0;
            while (!got && w < 5000) begin
                @(negedge clock);
                got = (src == 0) ? src0_ready : src1_ready;
                w++;
            end
            if (!got) begin
                check_eq("ready_timeout", 0, 1);
                k = n;
            end
            @(posedge clock);
            #1;
        end
        if (src == 0) begin src0_valid = 1'b0; src0_last = 1'b0; end
        else begin src1_valid = 1'b0; src1_last = 1'b0; end
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_n < target && t < 4000) begin
            @(posedge clock);
            t++;
        end
        #1;
        if (done_n < target) check_eq("pkt_done_timeout", done_n, target);
    endtask

    int d0, w0, l0, o0, c0, rise, t;

    initial begin
        // Reset values
        repeat (3) @(posedge clock);
        #1;
        check_eq("reset_grant", grant, 0);
        check_eq("reset_ready", {src0_ready, src1_ready}, 0);
        check_eq("reset_strobes", {wrreq, load_1k, wr_clear, wr_en, overrun}, 0);
        check_eq("reset_pkt_done", pkt_done, 0);
        reset = 1'b0;

        // Round-robin with both requests held
        d0 = done_n;
        src0_req = 1'b1;
        src1_req = 1'b1;
        fork
            begin send_pkt(0, 3, 'h20, 1'b1); send_pkt(0, 3, 'h30, 1'b1); end
            begin send_pkt(1, 3, 'h40, 1'b1); send_pkt(1, 3, 'h50, 1'b1); end
        join
        src0_req = 1'b0;
        src1_req = 1'b0;
        wait_done(d0 + 4);
        check_eq("rr_grant_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            check_eq("rr_grant0", grant_log[0], 2'b01);
            check_eq("rr_grant1", grant_log[1], 2'b10);
            check_eq("rr_grant2", grant_log[2], 2'b01);
            check_eq("rr_grant3", grant_log[3], 2'b10);
        end

        // Single packet from src0
        d0 = done_n; w0 = wrreq_n; l0 = load_n;
        src0_req = 1'b1;
        send_pkt(0, 5, 'h10, 1'b1);
        src0_req = 1'b0;
        wait_done(d0 + 1);
        check_eq("single_wrreq_count", wrreq_n - w0, 5);
        check_eq("single_load_count", load_n - l0, 1);
        check_eq("single_pkt_done", last_done, 2'b01);
        check_eq("single_drain_spacing", done_cyc - load_cyc, DRAIN + 1);
        check_eq("single_grant_idle", grant, 0);
        check_eq("single_wr_en_off", wr_en, 0);

        // Backpressure: queue full for three cycles mid-packet
        d0 = done_n; w0 = wrreq_n;
        src0_req = 1'b1;
        fork
            send_pkt(0, 8, 'h70, 1'b1);
            begin
                t = 0;
                while (wrreq_n < w0 + 3 && t < 200) begin
                    @(negedge clock);
                    t++;
                end
                @(posedge clock);
                #1;
                wrq_full = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clock);
                    check_eq("bp_ready_low", src0_ready, 0);
                end
                @(posedge clock);
                #1;
                wrq_full = 1'b0;
                @(negedge clock);
                check_eq("bp_ready_resume", src0_ready, 1);
            end
        join
        src0_req = 1'b0;
        wait_done(d0 + 1);
        check_eq("bp_wrreq_count", wrreq_n - w0, 8);

        // Overrun: 1030 bytes from src1
        d0 = done_n; w0 = wrreq_n; l0 = load_n; o0 = overrun_n;
        src1_req = 1'b1;
        send_pkt(1, 1030, 0, 1'b1);
        src1_req = 1'b0;
        wait_done(d0 + 1);
        check_eq("ovr_wrreq_count", wrreq_n - w0, FRAME);
        check_eq("ovr_pulse_count", overrun_n - o0, 1);
        check_eq("ovr_pulse_position", overrun_at - w0, FRAME);
        check_eq("ovr_load_count", load_n - l0, 1);
        check_eq("ovr_pkt_done", last_done, 2'b10);

        // Drain hold: queue not empty well past the drain time
        d0 = done_n; l0 = load_n;
        wrq_empty = 1'b0;
        src0_req = 1'b1;
        send_pkt(0, 2, 'h60, 1'b1);
        src0_req = 1'b0;
        t = 0;
        while (load_n == l0 && t < 100) begin
            @(posedge clock);
            t++;
        end
        repeat (DRAIN + 100) @(posedge clock);
        #1;
        check_eq("hold_no_done", done_n - d0, 0);
        check_eq("hold_wr_en", wr_en, 1);
        wrq_empty = 1'b1;
        rise = cyc;
        wait_done(d0 + 1);
        check_eq("hold_done_cycle", done_cyc, rise + 1);

        // Abort mid-FILL after 100 bytes; round-robin pointer must survive
        d0 = done_n; l0 = load_n; c0 = clear_n; w0 = wrreq_n;
        src0_req = 1'b1;
        src1_req = 1'b1;
        send_pkt(1, 100, 'h80, 1'b0);
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        check_eq("abort_grant_clear", grant, 0);
        check_eq("abort_wr_clear", wr_clear, 1);
        @(posedge clock);
        #1;
        check_eq("abort_wr_clear_single", wr_clear, 0);
        check_eq("abort_rr_next", grant, 2'b10);
        check_eq("abort_no_load", load_n - l0, 0);
        check_eq("abort_no_done", done_n - d0, 0);
        src0_req = 1'b0;
        send_pkt(1, 3, 'h90, 1'b1);
        src1_req = 1'b0;
        wait_done(d0 + 1);
        check_eq("abort_clear_count", clear_n - c0, 1);
        check_eq("abort_wrreq_count", wrreq_n - w0, 103);
        check_eq("abort_load_count", load_n - l0, 1);

        // Asynchronous reset mid-frame
        src0_req = 1'b1;
        t = 0;
        while (grant != 2'b01 && t < 20) begin
            @(negedge clock);
            t++;
        end
        check_eq("rst_pre_grant", grant, 2'b01);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_async_grant", grant, 0);
        check_eq("rst_async_ready", src0_ready, 0);
        check_eq("rst_async_strobes", {wrreq, load_1k, wr_clear, wr_en, overrun, pkt_done}, 0);
        src0_req = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;

        check_eq("sb_src0_empty", exp_q0.size(), 0);
        check_eq("sb_src1_empty", exp_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ftdi_tx_scheduler.md
# ftdi_tx_scheduler

Arbitrates two packet sources (bulk data, status/ack) onto the single FTDI write path. Streams one granted packet at a time into the FTDI interface's 1 KiB packet queue. Fires the one-cycle `load_1k` that pads the packet to a 1024-byte frame, then waits for that frame to drain before granting again. Sits between the laser-link packet logic and the FTDI asynchronous-FIFO interface.

## Interface
Parameters:
- `FRAME_BYTES`, 1024: frame size; maximum payload bytes per packet.
- `DRAIN_CYCLES`, 1100: minimum wait after `load_1k` before the next grant; covers the 1k→big-queue transfer and padding.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `abort` in 1: synchronous flush of the write path.
- `src0_req`, `src1_req` in 1: source requests to send one packet.
- `src0_valid`, `src1_valid` in 1: byte valid.
- `src0_data`, `src1_data` in 8: byte.
- `src0_last`, `src1_last` in 1: final byte of the packet.
- `src0_ready`, `src1_ready` out 1: byte accepted when valid && ready.
- `grant` out 2: one-hot current owner; 00 when idle.
- `pkt_done` out 2: one-cycle pulse per source on frame completion.
- `overrun` out 1: one-cycle pulse when a packet is truncated at `FRAME_BYTES`.
- `wrq_full` in 1: 1k packet queue full.
- `wrq_empty` in 1: 1k packet queue empty.
- `wrreq` out 1: push to 1k packet queue.
- `data_wr` out 8: byte to push.
- `load_1k` out 1: start-frame strobe.
- `wr_clear` out 1: clear 1k packet queue.
- `wr_en` out 1: permit FTDI writes.

## Operation
- States: IDLE, FILL, DISCARD, LOAD, DRAIN.
- IDLE:
  - No request: stay.
  - Any request: pick the owner round-robin. `last_grant` (reset 1) gives priority to the source other than the last owner. Set `grant`, clear `byte_ct`, go to FILL.
- FILL: owner ready = !`wrq_full` && `byte_ct` < `FRAME_BYTES`.
  - Accept = owner valid && ready. `wrreq` = accept; `data_wr` = owner data (combinational, same cycle). `byte_ct`++ on accept.
  - Accept with last → LOAD.
  - Accept without last taking `byte_ct` to `FRAME_BYTES` → pulse `overrun`, go to DISCARD.
- DISCARD: owner ready = 1. Bytes are dropped (no `wrreq`). Accept with last → LOAD.
- LOAD:
  - One cycle: `load_1k` = 1.
  - Load `drain_ct` = `DRAIN_CYCLES`-1, go to DRAIN.
- DRAIN:
  - `drain_ct` decrements each cycle.
  - When `drain_ct`==0 && `wrq_empty`: pulse `pkt_done[owner]`, update `last_grant`, set `grant`=00, go to IDLE.
  - If `wrq_empty` is low, hold at 0.
- `wr_en` = 1 in LOAD and DRAIN, 0 otherwise.
- Non-owner ready is always 0. `grant` is held from IDLE exit through DRAIN.
- `abort` (any state, highest priority): pulse `wr_clear` the next cycle, go to IDLE, set `grant`=00. No `pkt_done`; `last_grant` unchanged.
- Counter widths: `byte_ct` is clog2(`FRAME_BYTES`)+1 bits (11); `drain_ct` is 16 bits.
- Requests are level-sensitive. `req` dropping mid-packet has no effect; the packet ends only on last or abort.

## Timing
- Reset values:
  - `grant`=00, all ready=0, `wrreq`=0, `load_1k`=0, `wr_clear`=0, `wr_en`=0.
  - `pkt_done`=00, `overrun`=0, state IDLE.
- Grant latency: a request sampled in IDLE gives `grant` and ready one cycle later.
- Byte path: zero-latency passthrough to `wrreq`/`data_wr`. `wrq_full` deasserts ready in the same cycle.
- `load_1k` rises exactly one cycle after the last-byte accept (or the DISCARD last accept). It is never high two consecutive cycles.
- Minimum frame spacing: `pkt_done` comes no earlier than `DRAIN_CYCLES` cycles after the `load_1k` cycle.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). The bench clears the FTDI queues separately.

## Test plan
- Single packet: src0 sends 5 bytes 0x10..0x14, last on 0x14 → five `wrreq` with matching `data_wr`; `load_1k` one cycle later; `pkt_done`=01 after ≥1100 cycles; `grant` back to 00.
- Round-robin: both requests held continuously → grants alternate 01,10,01,10. After reset the first grant is 01.
- Backpressure: `wrq_full` high for 3 cycles mid-packet → src0 ready low exactly those cycles; no byte lost or duplicated.
- Overrun: src1 sends 1030 bytes, last on byte 1030 → exactly 1024 `wrreq`; `overrun` pulses with the 1024th accept; 6 bytes discarded; one `load_1k`.
- Drain hold: `wrq_empty` held low past `DRAIN_CYCLES` → `pkt_done` only on the cycle after `wrq_empty` rises.
- Abort mid-FILL after 100 bytes → `wr_clear` one-cycle pulse, no `load_1k`, no `pkt_done`; the next grant still follows round-robin from the previous `last_grant`.
